// File: rtl/m68k_sdram_bridge.sv
// rtl/m68k_sdram_bridge.sv - 68000 bus front end for the 125 MHz SDRAM controller
// Synchronises CPU strobes, decodes the RAM window and holds controller strobes for a fixed access time.
module m68k_sdram_bridge #(
   parameter logic [1:0] RAM_BASE    = 2'b00,
   parameter int         ACK_DELAY   = 20,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk125_mhz,
   input  logic        rstn,
   input  logic [23:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic        cpu_asn,
   input  logic        cpu_udsn,
   input  logic        cpu_ldsn,
   input  logic        cpu_rw,
   output logic [15:0] cpu_dout,
   output logic        cpu_dtackn,
   output logic [23:0] ram_addr,
   output logic [15:0] ram_din,
   input  logic [15:0] ram_dout,
   output logic        ram_asn,
   output logic        ram_udsn,
   output logic        ram_ldsn,
   output logic        ram_rw
);

   localparam int            CW       = $clog2(ACK_DELAY + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_DELAY - 1);

   typedef enum logic [2:0] {IDLE, MISS, ARM, ACCESS, ACK} state_t;

   state_t                      state, state_nxt;
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic                        s_asn, s_udsn, s_ldsn, s_rw;
   logic [CW-1:0]               count;
   logic                        enter_arm, enter_access, enter_ack, release_all;

   always_ff @(posedge clk125_mhz or negedge rstn) begin
      if (!rstn) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], {cpu_asn, cpu_udsn, cpu_ldsn, cpu_rw}};
   end

   assign {s_asn, s_udsn, s_ldsn, s_rw} = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk125_mhz or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // A released address strobe always wins, so an aborted cycle never reaches ACK.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!s_asn) state_nxt = (cpu_addr[23:22] == RAM_BASE) ? ARM : MISS;
         MISS:    if (s_asn) state_nxt = IDLE;
         ARM:     if (s_asn) state_nxt = IDLE;
                  else if (!(s_udsn && s_ldsn)) state_nxt = ACCESS;
         ACCESS:  if (s_asn) state_nxt = IDLE;
                  else if (count == CNT_LAST) state_nxt = ACK;
         ACK:     if (s_asn) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign enter_arm    = (state == IDLE)   && (state_nxt == ARM);
   assign enter_access = (state == ARM)    && (state_nxt == ACCESS);
   assign enter_ack    = (state == ACCESS) && (state_nxt == ACK);
   assign release_all  = (state != IDLE)   && (state_nxt == IDLE);

   always_ff @(posedge clk125_mhz or negedge rstn) begin
      if (!rstn) begin
         count      <= '0;
         cpu_dout   <= '0;
         cpu_dtackn <= 1'b1;
         ram_addr   <= '0;
         ram_din    <= '0;
         ram_asn    <= 1'b1;
         ram_udsn   <= 1'b1;
         ram_ldsn   <= 1'b1;
         ram_rw     <= 1'b1;
      end else begin
         if (enter_arm) begin
            ram_addr <= cpu_addr;
            ram_rw   <= s_rw;
            ram_asn  <= 1'b0;
         end
         if (enter_access) begin
            ram_udsn <= s_udsn;
            ram_ldsn <= s_ldsn;
            ram_din  <= cpu_din;
         end
         if (enter_access)
            count <= '0;
         else if (state == ACCESS && count != CNT_LAST)
            count <= count + 1'b1;
         if (enter_ack) begin
            cpu_dtackn <= 1'b0;
            if (ram_rw) cpu_dout <= ram_dout;
         end
         if (release_all) begin
            cpu_dtackn <= 1'b1;
            ram_asn    <= 1'b1;
            ram_udsn   <= 1'b1;
            ram_ldsn   <= 1'b1;
            ram_rw     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_m68k_sdram_bridge.sv
// tb/tb_m68k_sdram_bridge.sv - directed self-checking bench for m68k_sdram_bridge
// Scenario tasks with hand-computed expectations; default parameters (ACK_DELAY=20, SYNC_STAGES=2).
module tb_m68k_sdram_bridge;

   logic        clk125_mhz = 1'b0;
   logic        rstn;
   logic [23:0] cpu_addr;
   logic [15:0] cpu_din;
   logic        cpu_asn, cpu_udsn, cpu_ldsn, cpu_rw;
   logic [15:0] cpu_dout;
   logic        cpu_dtackn;
   logic [23:0] ram_addr;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;
   logic        ram_asn, ram_udsn, ram_ldsn, ram_rw;

   logic        use_model;
   logic [15:0] ram_fixed;
   int          checks = 0;
   int          failures = 0;

   always #4 clk125_mhz = ~clk125_mhz;

   // Controller stand-in: fixed word, or a word derived from the presented address.
   assign ram_dout = use_model ? {8'hD0, ram_addr[7:0]} : ram_fixed;

   m68k_sdram_bridge dut (
      .clk125_mhz (clk125_mhz),
      .rstn       (rstn),
      .cpu_addr   (cpu_addr),
      .cpu_din    (cpu_din),
      .cpu_asn    (cpu_asn),
      .cpu_udsn   (cpu_udsn),
      .cpu_ldsn   (cpu_ldsn),
      .cpu_rw     (cpu_rw),
      .cpu_dout   (cpu_dout),
      .cpu_dtackn (cpu_dtackn),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout),
      .ram_asn    (ram_asn),
      .ram_udsn   (ram_udsn),
      .ram_ldsn   (ram_ldsn),
      .ram_rw     (ram_rw)
   );

   task automatic tick();
      @(posedge clk125_mhz);
      #1;
   endtask

   task automatic bus_idle();
      cpu_asn  = 1'b1;
      cpu_udsn = 1'b1;
      cpu_ldsn = 1'b1;
      cpu_rw   = 1'b1;
   endtask

   task automatic start_read(input logic [23:0] addr);
      cpu_addr = addr;
      cpu_rw   = 1'b1;
      cpu_asn  = 1'b0;
      cpu_udsn = 1'b0;
      cpu_ldsn = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      checks++;
      if ({cpu_dtackn, ram_asn, ram_udsn, ram_ldsn, ram_rw} !== 5'b11111) begin
         failures++;
         $display("FAIL reset_strobes got=%b want=11111", {cpu_dtackn, ram_asn, ram_udsn, ram_ldsn, ram_rw});
      end
      checks++;
      if (cpu_dout !== 16'h0000 || ram_addr !== 24'h0 || ram_din !== 16'h0) begin
         failures++;
         $display("FAIL reset_data got dout=%h addr=%h din=%h want 0", cpu_dout, ram_addr, ram_din);
      end
      rstn = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_read();
      int n;
      use_model = 1'b0;
      ram_fixed = 16'hBEEF;
      start_read(24'h001234);
      n = 0;
      while (ram_ldsn !== 1'b0 && n < 10) begin tick(); n++; end
      checks++;
      if (ram_ldsn !== 1'b0 || ram_addr !== 24'h001234 || ram_rw !== 1'b1) begin
         failures++;
         $display("FAIL read_access got ldsn=%b addr=%h rw=%b want 0/001234/1", ram_ldsn, ram_addr, ram_rw);
      end
      n = 0;
      while (cpu_dtackn !== 1'b0 && n < 40) begin tick(); n++; end
      checks++;
      if (n !== 20) begin
         failures++;
         $display("FAIL read_ack_delay got=%0d want=20", n);
      end
      checks++;
      if (cpu_dout !== 16'hBEEF) begin
         failures++;
         $display("FAIL read_data got=%h want=beef", cpu_dout);
      end
      bus_idle();
      tick();
      tick();
      checks++;
      if (cpu_dtackn !== 1'b0 || ram_asn !== 1'b0) begin
         failures++;
         $display("FAIL read_hold got dtackn=%b asn=%b want 0/0", cpu_dtackn, ram_asn);
      end
      tick();
      checks++;
      if ({cpu_dtackn, ram_asn, ram_udsn, ram_ldsn, ram_rw} !== 5'b11111) begin
         failures++;
         $display("FAIL read_release got=%b want=11111", {cpu_dtackn, ram_asn, ram_udsn, ram_ldsn, ram_rw});
      end
      tick();
   endtask

   task automatic test_byte_write();
      int n;
      cpu_addr = 24'h000200;
      cpu_din  = 16'h00A5;
      cpu_rw   = 1'b0;
      cpu_asn  = 1'b0;
      repeat (4) tick();
      checks++;
      if (ram_asn !== 1'b0 || ram_ldsn !== 1'b1 || ram_udsn !== 1'b1) begin
         failures++;
         $display("FAIL wr_arm_wait got asn=%b udsn=%b ldsn=%b want 0/1/1", ram_asn, ram_udsn, ram_ldsn);
      end
      cpu_ldsn = 1'b0;
      n = 0;
      while (ram_ldsn !== 1'b0 && n < 10) begin tick(); n++; end
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL wr_ds_latency got=%0d want=3", n);
      end
      checks++;
      if (ram_udsn !== 1'b1 || ram_din !== 16'h00A5 || ram_rw !== 1'b0 || ram_addr !== 24'h000200) begin
         failures++;
         $display("FAIL wr_latch got udsn=%b din=%h rw=%b addr=%h want 1/00a5/0/000200",
                  ram_udsn, ram_din, ram_rw, ram_addr);
      end
      cpu_udsn = 1'b0;
      repeat (4) tick();
      checks++;
      if (ram_udsn !== 1'b1) begin
         failures++;
         $display("FAIL wr_late_udsn got=%b want=1", ram_udsn);
      end
      n = 0;
      while (cpu_dtackn !== 1'b0 && n < 40) begin tick(); n++; end
      checks++;
      if (cpu_dtackn !== 1'b0 || cpu_dout !== 16'hBEEF) begin
         failures++;
         $display("FAIL wr_ack got dtackn=%b dout=%h want 0/beef", cpu_dtackn, cpu_dout);
      end
      bus_idle();
      repeat (4) tick();
   endtask

   task automatic test_miss();
      int bad;
      cpu_addr = 24'hC00000;
      cpu_rw   = 1'b1;
      cpu_asn  = 1'b0;
      cpu_ldsn = 1'b0;
      bad = 0;
      repeat (40) begin
         tick();
         if (ram_asn !== 1'b1 || cpu_dtackn !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL miss_quiet got=%0d bad cycles want=0", bad);
      end
      bus_idle();
      repeat (4) tick();
   endtask

   task automatic test_abort();
      int n;
      int saw_ack;
      ram_fixed = 16'h1111;
      start_read(24'h000300);
      n = 0;
      while (ram_ldsn !== 1'b0 && n < 10) begin tick(); n++; end
      repeat (5) tick();
      bus_idle();
      tick();
      tick();
      checks++;
      if (ram_ldsn !== 1'b0 || ram_asn !== 1'b0) begin
         failures++;
         $display("FAIL abort_hold got asn=%b ldsn=%b want 0/0", ram_asn, ram_ldsn);
      end
      tick();
      checks++;
      if ({ram_asn, ram_udsn, ram_ldsn} !== 3'b111) begin
         failures++;
         $display("FAIL abort_release got=%b want=111", {ram_asn, ram_udsn, ram_ldsn});
      end
      saw_ack = 0;
      repeat (30) begin
         tick();
         if (cpu_dtackn !== 1'b1 || ram_asn !== 1'b1) saw_ack++;
      end
      checks++;
      if (saw_ack !== 0 || cpu_dout !== 16'hBEEF) begin
         failures++;
         $display("FAIL abort_no_ack got bad=%0d dout=%h want 0/beef", saw_ack, cpu_dout);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int high_cnt;
      logic prev, relow;
      use_model = 1'b1;
      start_read(24'h000010);
      n = 0;
      while (cpu_dtackn !== 1'b0 && n < 50) begin tick(); n++; end
      checks++;
      if (cpu_dtackn !== 1'b0 || cpu_dout !== 16'hD010) begin
         failures++;
         $display("FAIL b2b_first got dtackn=%b dout=%h want 0/d010", cpu_dtackn, cpu_dout);
      end
      bus_idle();
      cpu_addr = 24'h000011;
      tick();
      start_read(24'h000011);
      high_cnt = 0;
      relow    = 1'b0;
      prev     = ram_asn;
      n = 0;
      while (!(relow && cpu_dtackn === 1'b0) && n < 60) begin
         tick();
         n++;
         if (ram_asn === 1'b1) high_cnt++;
         if (prev === 1'b1 && ram_asn === 1'b0) relow = 1'b1;
         prev = ram_asn;
      end
      checks++;
      if (!relow || high_cnt < 1) begin
         failures++;
         $display("FAIL b2b_gap got relow=%b high=%0d want 1/>=1", relow, high_cnt);
      end
      checks++;
      if (cpu_dtackn !== 1'b0 || cpu_dout !== 16'hD011 || ram_addr !== 24'h000011) begin
         failures++;
         $display("FAIL b2b_second got dtackn=%b dout=%h addr=%h want 0/d011/000011",
                  cpu_dtackn, cpu_dout, ram_addr);
      end
      bus_idle();
      repeat (4) tick();
   endtask

   task automatic test_reset_mid();
      int n;
      start_read(24'h000020);
      n = 0;
      while (ram_ldsn !== 1'b0 && n < 10) begin tick(); n++; end
      repeat (3) tick();
      rstn = 1'b0;
      #1;
      checks++;
      if ({cpu_dtackn, ram_asn, ram_udsn, ram_ldsn} !== 4'b1111 || cpu_dout !== 16'h0000) begin
         failures++;
         $display("FAIL reset_mid got strobes=%b dout=%h want 1111/0000",
                  {cpu_dtackn, ram_asn, ram_udsn, ram_ldsn}, cpu_dout);
      end
      bus_idle();
      tick();
      rstn = 1'b1;
      repeat (3) tick();
      checks++;
      if (ram_asn !== 1'b1 || cpu_dtackn !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_after got asn=%b dtackn=%b want 1/1", ram_asn, cpu_dtackn);
      end
   endtask

   initial begin
      rstn      = 1'b0;
      cpu_addr  = '0;
      cpu_din   = '0;
      use_model = 1'b0;
      ram_fixed = '0;
      bus_idle();
      test_reset();
      test_read();
      test_byte_write();
      test_miss();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
